regfile_scoreboard: RTL and testbench

- Parametrised successor of the Minisys decode-stage register file, built for the pipelined core.
- Holds NUM_REGS x DATA_W general registers with two combinational read ports and one write-back port.
- Adds a per-register scoreboard that tracks in-flight destination writes, plus an issue valid/ready handshake that stalls decode on RAW and WAW hazards.
- Sits between fetch/decode and execute; write-back comes from the MEM/WB stage.

---
 rtl/regfile_scoreboard_if.sv | 37 +++
 rtl/regfile_scoreboard.sv | 83 ++++++++
 tb/tb_regfile_scoreboard.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Issue / write-back / read bundle between decode and the scoreboarded register file.
// master = decode + MEM/WB side, slave = register file.
interface regfile_scoreboard_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int CNT_W    = $clog2(NUM_REGS + 1)
);
    logic                issue_valid;
    logic                issue_ready;
    logic [ADDR_W-1:0]   rs_addr;
    logic [ADDR_W-1:0]   rt_addr;
    logic                rs_used;
    logic                rt_used;
    logic [ADDR_W-1:0]   dst_addr;
    logic                dst_we;
    logic                wb_valid;
    logic [ADDR_W-1:0]   wb_addr;
    logic [DATA_W-1:0]   wb_data;
    logic [DATA_W-1:0]   rdata1;
    logic [DATA_W-1:0]   rdata2;
    logic [NUM_REGS-1:0] busy_vec;
    logic [CNT_W-1:0]    pending_cnt;
    logic                wb_err;

    modport master (
        output issue_valid, rs_addr, rt_addr, rs_used, rt_used, dst_addr, dst_we,
               wb_valid, wb_addr, wb_data,
        input  issue_ready, rdata1, rdata2, busy_vec, pending_cnt, wb_err
    );

    modport slave (
        input  issue_valid, rs_addr, rt_addr, rs_used, rt_used, dst_addr, dst_we,
               wb_valid, wb_addr, wb_data,
        output issue_ready, rdata1, rdata2, busy_vec, pending_cnt, wb_err
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with per-register scoreboard and RAW/WAW issue stall.
// Optional write-back forwarding to the read ports: define REGFILE_SB_BYPASS_EN.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int CNT_W    = $clog2(NUM_REGS + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    regfile_scoreboard_if.slave  bus
);
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]             busy_q, busy_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            err_q, err_d;

    logic wb_nz, byp_rs, byp_rt;
    logic rs_haz, rt_haz, waw, ready, fire;
    logic sb_set, sb_clr, spurious;

    always_comb begin
        wb_nz = bus.wb_valid & (bus.wb_addr != '0);
`ifdef REGFILE_SB_BYPASS_EN
        byp_rs = wb_nz & (bus.wb_addr == bus.rs_addr);
        byp_rt = wb_nz & (bus.wb_addr == bus.rt_addr);
`else
        byp_rs = 1'b0;
        byp_rt = 1'b0;
`endif
        rs_haz = bus.rs_used & (bus.rs_addr != '0) & busy_q[bus.rs_addr] & ~byp_rs;
        rt_haz = bus.rt_used & (bus.rt_addr != '0) & busy_q[bus.rt_addr] & ~byp_rt;
        // A write-back landing on the destination this edge retires the older writer.
        waw    = bus.dst_we & (bus.dst_addr != '0) & busy_q[bus.dst_addr]
               & ~(bus.wb_valid & (bus.wb_addr == bus.dst_addr));
        ready  = ~(rs_haz | rt_haz | waw);
        fire   = bus.issue_valid & ready;

        sb_set   = fire & bus.dst_we & (bus.dst_addr != '0);
        sb_clr   = wb_nz & busy_q[bus.wb_addr];
        spurious = wb_nz & ~busy_q[bus.wb_addr];
    end

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wb_nz) begin
            regs_d[bus.wb_addr] = bus.wb_data;
            busy_d[bus.wb_addr] = 1'b0;
        end
        // Set after clear so a same-register set/clear leaves the bit pending.
        if (sb_set) busy_d[bus.dst_addr] = 1'b1;
        regs_d[0] = '0;
        cnt_d = cnt_q + CNT_W'(sb_set) - CNT_W'(sb_clr);
        err_d = err_q | spurious;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= DATA_W'(i);
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        bus.rdata1 = (bus.rs_addr == '0) ? '0 : regs_q[bus.rs_addr];
        bus.rdata2 = (bus.rt_addr == '0) ? '0 : regs_q[bus.rt_addr];
        if (byp_rs) bus.rdata1 = bus.wb_data;
        if (byp_rt) bus.rdata2 = bus.wb_data;
    end

    assign bus.issue_ready = ready;
    assign bus.busy_vec    = busy_q;
    assign bus.pending_cnt = cnt_q;
    assign bus.wb_err      = err_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed scenarios plus random traffic against an array/flag model of the scoreboarded regfile.
module tb_regfile_scoreboard;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    regfile_scoreboard_if #(.DATA_W(DW), .NUM_REGS(NR)) bus();
    regfile_scoreboard #(.DATA_W(DW), .NUM_REGS(NR)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    logic [DW-1:0] mregs [NR];
    bit            mbusy [NR];
    bit            merr;
    int            vectors = 0;
    int            miscmp  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) begin
            mregs[i] = DW'(i);
            mbusy[i] = 1'b0;
        end
        mregs[0] = '0;
        merr = 1'b0;
    endfunction

    function automatic bit byp(input logic [AW-1:0] a);
`ifdef REGFILE_SB_BYPASS_EN
        return bus.wb_valid && a != 0 && bus.wb_addr == a;
`else
        return (a == 5'd0) && 1'b0;
`endif
    endfunction

    function automatic bit m_ready();
        bit haz_s, haz_t, w;
        haz_s = bus.rs_used && bus.rs_addr != 0 && mbusy[bus.rs_addr] && !byp(bus.rs_addr);
        haz_t = bus.rt_used && bus.rt_addr != 0 && mbusy[bus.rt_addr] && !byp(bus.rt_addr);
        w = bus.dst_we && bus.dst_addr != 0 && mbusy[bus.dst_addr]
            && !(bus.wb_valid && bus.wb_addr == bus.dst_addr);
        return !(haz_s || haz_t || w);
    endfunction

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (byp(a)) return bus.wb_data;
        return mregs[a];
    endfunction

    function automatic logic [NR-1:0] m_vec();
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) v[i] = mbusy[i];
        return v;
    endfunction

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < NR; i++) n += int'(mbusy[i]);
        return n;
    endfunction

    task automatic check_all();
        chk("ready",  64'(bus.issue_ready), 64'(m_ready()));
        chk("rdata1", 64'(bus.rdata1),      64'(m_read(bus.rs_addr)));
        chk("rdata2", 64'(bus.rdata2),      64'(m_read(bus.rt_addr)));
        chk("busy",   64'(bus.busy_vec),    64'(m_vec()));
        chk("cnt",    64'(bus.pending_cnt), 64'(m_cnt()));
        chk("err",    64'(bus.wb_err),      64'(merr));
    endtask

    task automatic model_update();
        bit fire;
        fire = bus.issue_valid && m_ready();
        if (bus.wb_valid && bus.wb_addr != 0) begin
            if (!mbusy[bus.wb_addr]) merr = 1'b1;
            mregs[bus.wb_addr] = bus.wb_data;
            mbusy[bus.wb_addr] = 1'b0;
        end
        if (fire && bus.dst_we && bus.dst_addr != 0) mbusy[bus.dst_addr] = 1'b1;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        #1;
        check_all();
        model_update();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        bus.issue_valid = 0; bus.rs_addr = '0; bus.rt_addr = '0;
        bus.rs_used = 0; bus.rt_used = 0; bus.dst_addr = '0; bus.dst_we = 0;
        bus.wb_valid = 0; bus.wb_addr = '0; bus.wb_data = '0;
    endtask

    task automatic issue(input logic [AW-1:0] d);
        idle();
        bus.issue_valid = 1; bus.dst_we = 1; bus.dst_addr = d;
    endtask

    initial begin
        int q[$];
        idle();
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Reset state
        bus.rs_addr = 5'd5;
        #1;
        chk("rst_r5",   64'(bus.rdata1), 64'd5);
        chk("rst_r0",   64'(bus.rdata2), 64'd0);
        chk("rst_busy", 64'(bus.busy_vec), 64'd0);
        chk("rst_cnt",  64'(bus.pending_cnt), 64'd0);
        chk("rst_err",  64'(bus.wb_err), 64'd0);
        step();

        // RAW on r3
        issue(5'd3); step();
        idle(); bus.issue_valid = 1; bus.rs_used = 1; bus.rs_addr = 5'd3;
        #1 chk("raw_stall", 64'(bus.issue_ready), 64'd0);
        step();
        bus.wb_valid = 1; bus.wb_addr = 5'd3; bus.wb_data = 32'hDEADBEEF;
        #1;
`ifdef REGFILE_SB_BYPASS_EN
        chk("raw_byp_rdy",  64'(bus.issue_ready), 64'd1);
        chk("raw_byp_data", 64'(bus.rdata1), 64'hDEADBEEF);
        step();
`else
        chk("raw_wb_rdy", 64'(bus.issue_ready), 64'd0);
        step();
        bus.wb_valid = 0;
        #1;
        chk("raw_late_rdy",  64'(bus.issue_ready), 64'd1);
        chk("raw_late_data", 64'(bus.rdata1), 64'hDEADBEEF);
        step();
`endif

        // WAW on r7
        issue(5'd7); step();
        issue(5'd7);
        #1 chk("waw_stall", 64'(bus.issue_ready), 64'd0);
        step();
        bus.wb_valid = 1; bus.wb_addr = 5'd7; bus.wb_data = 32'h0000_0077;
        #1 chk("waw_wb_rdy", 64'(bus.issue_ready), 64'd1);
        step();
        idle(); bus.rs_addr = 5'd7;
        #1;
        chk("waw_busy7", 64'(bus.busy_vec[7]), 64'd1);
        chk("waw_cnt",   64'(bus.pending_cnt), 64'd1);
        chk("waw_data",  64'(bus.rdata1), 64'h77);
        step();
        idle(); bus.wb_valid = 1; bus.wb_addr = 5'd7; bus.wb_data = 32'h0000_0777; step();

        // Zero register
        issue(5'd0); step();
        idle(); bus.wb_valid = 1; bus.wb_addr = 5'd0; bus.wb_data = 32'h1234; step();
        idle();
        #1;
        chk("zero_r0",   64'(bus.rdata1), 64'd0);
        chk("zero_busy", 64'(bus.busy_vec), 64'd0);
        chk("zero_err",  64'(bus.wb_err), 64'd0);
        step();

        // Spurious write-back, then asynchronous reset mid-flight
        issue(5'd5); bus.wb_valid = 1; bus.wb_addr = 5'd9; bus.wb_data = 32'h9999_0009; step();
        idle(); bus.rt_addr = 5'd9;
        #1;
        chk("spur_data", 64'(bus.rdata2), 64'h99990009);
        chk("spur_err",  64'(bus.wb_err), 64'd1);
        step();
        idle(); step();
        #1 chk("spur_sticky", 64'(bus.wb_err), 64'd1);
        #1 reset = 1'b0;
        #1;
        chk("async_err",  64'(bus.wb_err), 64'd0);
        chk("async_busy", 64'(bus.busy_vec), 64'd0);
        chk("async_cnt",  64'(bus.pending_cnt), 64'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;

        // Pending counter
        issue(5'd1); step();
        issue(5'd2); step();
        issue(5'd4); step();
        idle(); bus.wb_valid = 1; bus.wb_addr = 5'd2; bus.wb_data = 32'hA5A5_0002;
        #1 chk("cnt3", 64'(bus.pending_cnt), 64'd3);
        step();
        idle();
        #1;
        chk("cnt2",    64'(bus.pending_cnt), 64'd2);
        chk("busy_12", 64'(bus.busy_vec), 64'h12);
        step();

        // Random traffic, small address range to provoke hazards
        for (int n = 0; n < 600; n++) begin
            bus.issue_valid = 1'($urandom);
            bus.rs_used     = 1'($urandom);
            bus.rt_used     = 1'($urandom);
            bus.dst_we      = 1'($urandom);
            bus.rs_addr     = AW'($urandom_range(0, 15));
            bus.rt_addr     = AW'($urandom_range(0, 15));
            bus.dst_addr    = AW'($urandom_range(0, 15));
            bus.wb_valid    = 1'($urandom);
            bus.wb_data     = $urandom;
            q.delete();
            for (int i = 1; i < NR; i++) if (mbusy[i]) q.push_back(i);
            if (q.size() > 0 && $urandom_range(0, 9) < 9)
                bus.wb_addr = AW'(q[$urandom_range(0, q.size() - 1)]);
            else
                bus.wb_addr = AW'($urandom_range(0, 15));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end
endmodule
